// File: rtl/rv_decode_pkg.sv
// Shared decode definitions: opcodes, ID/EX field bundle,
// NOP values and the immediate generator.
package rv_decode_pkg;

   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] LOAD     = 7'b0000011;
   localparam logic [6:0] JALR     = 7'b1100111;
   localparam logic [6:0] STORE    = 7'b0100011;
   localparam logic [6:0] BRANCH   = 7'b1100011;
   localparam logic [6:0] LUI      = 7'b0110111;
   localparam logic [6:0] AUIPC    = 7'b0010111;
   localparam logic [6:0] JAL      = 7'b1101111;
   localparam logic [6:0] OP_IMM32 = 7'b0011011;

   typedef struct packed {
      logic [6:0] opcode;
      logic [4:0] rd;
      logic [2:0] func3;
      logic [6:0] func7;
      logic [4:0] rs1;
      logic [4:0] rs2;
   } id_fields_t;

   // Empty ID/EX slot looks like addi x0,x0,0
   localparam id_fields_t NOP_FIELDS = '{
      opcode: OP_IMM,
      rd:     5'd0,
      func3:  3'd0,
      func7:  7'd0,
      rs1:    5'd0,
      rs2:    5'd0
   };

   function automatic id_fields_t split_fields(input logic [31:0] inst);
      id_fields_t f;
      f.opcode = inst[6:0];
      f.rd     = inst[11:7];
      f.func3  = inst[14:12];
      f.func7  = inst[31:25];
      f.rs1    = inst[19:15];
      f.rs2    = inst[24:20];
      return f;
   endfunction

   // Sign-extended immediate; upper half cleared for 32-bit builds
   function automatic logic [63:0] imm_gen(input logic [31:0] inst,
                                           input int xlen);
      logic [63:0] r;
      logic [31:0] s;
      s = {32{inst[31]}};
      case (inst[6:0])
         OP_IMM, LOAD, JALR, OP_IMM32:
            r = {s, s[31:12], inst[31:20]};
         STORE:
            r = {s, s[31:12], inst[31:25], inst[11:7]};
         BRANCH:
            r = {s, s[31:13], inst[31], inst[7],
                 inst[30:25], inst[11:8], 1'b0};
         LUI, AUIPC:
            r = {s, inst[31:12], 12'b0};
         JAL:
            r = {s, s[31:21], inst[31], inst[19:12],
                 inst[20], inst[30:21], 1'b0};
         default:
            r = 64'd0;
      endcase
      if (xlen == 32) r[63:32] = 32'd0;
      return r;
   endfunction

endpackage

// File: rtl/id_stage_hs_regfile.sv
// Register file with one write port and three read ports
// that see a same-cycle write-back through a bypass.
module regfile_bypass
   import rv_decode_pkg::*;
#(
   parameter int NREG = 32,
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   input  logic [4:0]      dbg_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic [XLEN-1:0] dbg_data
);

   localparam int AW = $clog2(NREG);

   logic [XLEN-1:0] rf [NREG];
   logic            wr_ok;

   assign wr_ok = wb_en && (wb_rd != 5'd0) && (int'(wb_rd) < NREG);

   function automatic logic [XLEN-1:0] rd_port(input logic [4:0] a);
      logic [XLEN-1:0] v;
      v = '0;
      if (a != 5'd0 && int'(a) < NREG) begin
         if (wr_ok && a == wb_rd) v = wb_data;
         else                     v = rf[a[AW-1:0]];
      end
      return v;
   endfunction

   // Architectural register update; x0 and out-of-range slots never written
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else if (wr_ok) begin
         rf[wb_rd[AW-1:0]] <= wb_data;
      end
   end

   // Bypassed read ports
   always_comb begin
      rs1_data = rd_port(rs1_addr);
      rs2_data = rd_port(rs2_addr);
      dbg_data = rd_port(dbg_addr);
   end

endmodule

// File: rtl/id_stage_hs.sv
// Instruction-decode stage: operand read, immediate generation
// and a handshaked ID/EX register with stall-time operand refresh.
module id_stage_hs
   import rv_decode_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [6:0]      out_opcode,
   output logic [4:0]      out_rd,
   output logic [2:0]      out_func3,
   output logic [6:0]      out_func7,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [XLEN-1:0] out_data1,
   output logic [XLEN-1:0] out_data2,
   output logic [XLEN-1:0] out_imm,
   input  logic [4:0]      dbg_raddr,
   output logic [XLEN-1:0] dbg_rdata
);

   id_fields_t      fld;
   id_fields_t      nxt_fld;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [63:0]     imm_w;
   logic            load;
   logic            wb_live;

   assign nxt_fld  = split_fields(in_inst);
   assign imm_w    = imm_gen(in_inst, XLEN);
   assign in_ready = !out_valid || out_ready;
   assign load     = in_valid && in_ready;
   assign wb_live  = wb_en && (wb_rd != 5'd0) && (int'(wb_rd) < NREG);

   regfile_bypass #(
      .NREG (NREG),
      .XLEN (XLEN)
   ) u_rf (
      .clk      (clk),
      .rst      (rst),
      .wb_en    (wb_en),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .rs1_addr (nxt_fld.rs1),
      .rs2_addr (nxt_fld.rs2),
      .dbg_addr (dbg_raddr),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .dbg_data (dbg_rdata)
   );

   // ID/EX register: reset/flush to NOP, load, stall refresh, or drain
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         out_valid <= 1'b0;
         fld       <= NOP_FIELDS;
         out_data1 <= '0;
         out_data2 <= '0;
         out_imm   <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         fld       <= nxt_fld;
         out_data1 <= rs1_data;
         out_data2 <= rs2_data;
         out_imm   <= imm_w[XLEN-1:0];
      end else if (out_valid && !out_ready) begin
         if (wb_live && wb_rd == fld.rs1) out_data1 <= wb_data;
         if (wb_live && wb_rd == fld.rs2) out_data2 <= wb_data;
      end else begin
         out_valid <= 1'b0;
      end
   end

   assign out_opcode = fld.opcode;
   assign out_rd     = fld.rd;
   assign out_func3  = fld.func3;
   assign out_func7  = fld.func7;
   assign out_rs1    = fld.rs1;
   assign out_rs2    = fld.rs2;

endmodule

// File: tb/tb_id_stage_hs.sv
// Directed bench for id_stage_hs: a 64-bit/32-reg build
// and a 64-bit/16-reg build driven from the same stimulus.
module tb_id_stage_hs;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, wb_en, out_ready;
   logic [31:0] in_inst;
   logic [4:0]  wb_rd, dbg_raddr;
   logic [63:0] wb_data;

   logic        in_ready, out_valid;
   logic [6:0]  out_opcode, out_func7;
   logic [4:0]  out_rd, out_rs1, out_rs2;
   logic [2:0]  out_func3;
   logic [63:0] out_data1, out_data2, out_imm, dbg_rdata;

   logic        e_in_ready, e_out_valid;
   logic [6:0]  e_opcode, e_func7;
   logic [4:0]  e_rd, e_rs1, e_rs2;
   logic [2:0]  e_func3;
   logic [63:0] e_data1, e_data2, e_imm, e_dbg;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   id_stage_hs #(.XLEN(64), .NREG(32)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_opcode(out_opcode), .out_rd(out_rd), .out_func3(out_func3),
      .out_func7(out_func7), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_data1(out_data1), .out_data2(out_data2), .out_imm(out_imm),
      .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
   );

   id_stage_hs #(.XLEN(64), .NREG(16)) dut16 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(e_in_ready), .in_inst(in_inst),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .out_valid(e_out_valid), .out_ready(out_ready),
      .out_opcode(e_opcode), .out_rd(e_rd), .out_func3(e_func3),
      .out_func7(e_func7), .out_rs1(e_rs1), .out_rs2(e_rs2),
      .out_data1(e_data1), .out_data2(e_data2), .out_imm(e_imm),
      .dbg_raddr(dbg_raddr), .dbg_rdata(e_dbg)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = 32'h0;
      wb_en = 1'b0; wb_rd = 5'd0; wb_data = 64'd0;
      out_ready = 1'b1; dbg_raddr = 5'd0;

      // reset, two cycles
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_opcode", {57'd0, out_opcode}, 64'h13);
      chk("rst_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_rd", {59'd0, out_rd}, 64'd0);
      chk("rst_data1", out_data1, 64'd0);
      chk("rst_imm", out_imm, 64'd0);
      chk("rst16_opcode", {57'd0, e_opcode}, 64'h13);
      for (int a = 0; a < 32; a++) begin
         dbg_raddr = a[4:0];
         #1;
         chk("rst_dbg", dbg_rdata, 64'd0);
      end

      // add x1,x5,x5 loads while x5 is written: bypass
      in_valid = 1'b1; in_inst = 32'h005280B3;
      wb_en = 1'b1; wb_rd = 5'd5; wb_data = 64'hDEAD;
      tick();
      chk("byp_valid", {63'd0, out_valid}, 64'd1);
      chk("byp_data1", out_data1, 64'hDEAD);
      chk("byp_data2", out_data2, 64'hDEAD);
      chk("byp_opcode", {57'd0, out_opcode}, 64'h33);
      chk("byp_rd", {59'd0, out_rd}, 64'd1);
      chk("byp_rs1", {59'd0, out_rs1}, 64'd5);
      chk("byp_imm", out_imm, 64'd0);
      chk("byp16_data1", e_data1, 64'hDEAD);

      // write to x0, addi x1,x0,-1; also dbg bypass of x6
      in_inst = 32'hFFF00093;
      wb_rd = 5'd0; wb_data = 64'h1234;
      dbg_raddr = 5'd0;
      #1;
      chk("dbg_x0_byp", dbg_rdata, 64'd0);
      wb_rd = 5'd6; wb_data = 64'h77; dbg_raddr = 5'd6;
      #1;
      chk("dbg_x6_byp", dbg_rdata, 64'h77);
      wb_rd = 5'd0; wb_data = 64'h1234;
      tick();
      chk("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("addi_data1", out_data1, 64'd0);
      chk("addi_func3", {61'd0, out_func3}, 64'd0);
      wb_en = 1'b0; dbg_raddr = 5'd0;
      #1;
      chk("x0_reads0", dbg_rdata, 64'd0);
      dbg_raddr = 5'd5;
      #1;
      chk("x5_stored", dbg_rdata, 64'hDEAD);

      // beq x0,x0,-4
      in_inst = 32'hFE000EE3;
      tick();
      chk("beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("beq_func7", {57'd0, out_func7}, 64'h7F);

      // sw x5,12(x0)
      in_inst = 32'h00502623;
      tick();
      chk("sw_imm", out_imm, 64'd12);
      chk("sw_data2", out_data2, 64'hDEAD);
      chk("sw_func3", {61'd0, out_func3}, 64'd2);

      // jal x0,8
      in_inst = 32'h0080006F;
      tick();
      chk("jal_imm", out_imm, 64'd8);

      // lui x1,0x80000 while x7 <= 0x70
      in_inst = 32'h800000B7;
      wb_en = 1'b1; wb_rd = 5'd7; wb_data = 64'h70;
      tick();
      chk("lui_imm", out_imm, 64'hFFFF_FFFF_8000_0000);
      chk("lui16_imm", e_imm, 64'hFFFF_FFFF_8000_0000);

      // add x3,x7,x8 loads (out_ready still high)
      in_inst = 32'h008381B3; wb_en = 1'b0;
      tick();
      chk("stl_ld_data1", out_data1, 64'h70);
      chk("stl_ld_data2", out_data2, 64'd0);

      // stall: x8 written, new addi offered but not taken
      out_ready = 1'b0; in_inst = 32'hFFF00093;
      wb_en = 1'b1; wb_rd = 5'd8; wb_data = 64'h55;
      #1;
      chk("stl_ready0", {63'd0, in_ready}, 64'd0);
      tick();
      chk("stl_data2", out_data2, 64'h55);
      chk("stl_data1", out_data1, 64'h70);
      chk("stl_rd", {59'd0, out_rd}, 64'd3);
      chk("stl_imm", out_imm, 64'd0);
      chk("stl_valid", {63'd0, out_valid}, 64'd1);
      chk("stl_ready1", {63'd0, in_ready}, 64'd0);
      wb_en = 1'b0;
      tick();
      chk("stl_hold_d2", out_data2, 64'h55);
      chk("stl_hold_op", {57'd0, out_opcode}, 64'h33);

      // flush while stalled, with wb to x9
      flush = 1'b1; wb_en = 1'b1; wb_rd = 5'd9; wb_data = 64'h99;
      tick();
      flush = 1'b0; wb_en = 1'b0; dbg_raddr = 5'd9;
      #1;
      chk("fl_valid", {63'd0, out_valid}, 64'd0);
      chk("fl_opcode", {57'd0, out_opcode}, 64'h13);
      chk("fl_rd", {59'd0, out_rd}, 64'd0);
      chk("fl_data1", out_data1, 64'd0);
      chk("fl_imm", out_imm, 64'd0);
      chk("fl_dbg9", dbg_rdata, 64'h99);
      chk("fl_ready", {63'd0, in_ready}, 64'd1);

      // drain: nothing offered, out_valid drops after one load
      out_ready = 1'b1; in_inst = 32'h005280B3;
      tick();
      in_valid = 1'b0;
      tick();
      chk("drain_valid", {63'd0, out_valid}, 64'd0);

      // write x20: ignored by the 16-register build
      wb_en = 1'b1; wb_rd = 5'd20; wb_data = 64'hABC; dbg_raddr = 5'd20;
      #1;
      chk("e_byp20", e_dbg, 64'd0);
      tick();
      wb_en = 1'b0;
      #1;
      chk("e_x20", e_dbg, 64'd0);
      chk("x20", dbg_rdata, 64'hABC);
      dbg_raddr = 5'd5;
      #1;
      chk("e_x5", e_dbg, 64'hDEAD);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/id_stage_hs.md
Name: id_stage_hs

Overview:
- Parametrised instruction-decode stage: register file, field extraction, immediate generation and an ID/EX pipeline register.
- Generalises the first-generation decode stage:
  - configurable XLEN and register count;
  - explicit write-back enable;
  - single-edge register-file write with bypass;
  - valid/ready handshake with stall-hold operand refresh;
  - synchronous flush.
- Sits between the fetch stage and the execute stage.

Parameters:
- XLEN, 64, datapath width; 32 or 64 only.
- NREG, 32, architectural register count; 32 (RV-I) or 16 (RV-E).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous kill of the ID/EX register.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_inst  in  32  instruction word.
- wb_en  in  1  write-back strobe.
- wb_rd  in  5  write-back destination register.
- wb_data  in  XLEN  write-back data.
- out_valid  out  1  ID/EX register holds a live instruction.
- out_ready  in  1  execute stage accepts it.
- out_opcode  out  7  inst[6:0].
- out_rd  out  5  inst[11:7].
- out_func3  out  3  inst[14:12].
- out_func7  out  7  inst[31:25].
- out_rs1  out  5  inst[19:15].
- out_rs2  out  5  inst[24:20].
- out_data1  out  XLEN  rs1 operand.
- out_data2  out  XLEN  rs2 operand.
- out_imm  out  XLEN  sign-extended immediate.
- dbg_raddr  in  5  side read address (branch/jalr control path).
- dbg_rdata  out  XLEN  bypassed side read data.

Behaviour:
- Reset (rst=1 at a clk edge):
  - all RF entries are 0;
  - out_valid=0, out_opcode=7'b0010011;
  - all other out_* fields and operands are 0.
  - in_ready=1 in the first cycle after reset.
- RF write, on the clk edge:
  - Condition: wb_en=1, wb_rd!=0 and wb_rd<NREG.
  - x0 always reads 0.
  - Addresses >=NREG read 0; writes to them are ignored.
- Bypassed read, combinational, used for rs1, rs2 and dbg:
  - If wb_en=1, addr==wb_rd and addr!=0, result = wb_data.
  - Otherwise result = RF[addr].
  - dbg_rdata uses this rule on dbg_raddr.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - load = in_valid && in_ready.
- On load:
  - All fields capture from in_inst.
  - out_data1/out_data2 capture the bypassed reads of inst[19:15]/inst[24:20].
  - out_imm captures the generated immediate.
  - out_valid <= 1.
- No load and out_ready=1: out_valid <= 0; fields are don't-care.
- Stall hold (out_valid=1, out_ready=0):
  - All fields hold.
  - If wb_en=1, wb_rd==out_rs1 and out_rs1!=0: out_data1 <= wb_data.
  - Same rule for out_rs2/out_data2.
  - If rs1==rs2, both operands update.
- Flush (synchronous):
  - Priority: rst > flush > load.
  - out_valid <= 0; fields return to reset/NOP values.
  - The RF write in the same cycle is still performed.
- Latency: 1 cycle from load to out_valid. Full throughput when out_ready=1.
- Immediate by opcode, sign-extended from inst[31] to XLEN:
  - 0010011, 0000011, 1100111, 0011011: I-type, inst[31:20].
  - 0100011: S-type, {inst[31:25], inst[11:7]}.
  - 1100011: B-type, {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - 0110111, 0010111: U-type, {inst[31:12], 12'b0}, sign-extended for XLEN=64.
  - 1101111: J-type, {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - Any other opcode: 0.

Decomposition:
- Shared package rv_decode_pkg holds:
  - opcode constants (OP_IMM, LOAD, JALR, STORE, BRANCH, LUI, AUIPC, JAL, OP_IMM32);
  - NOP field values;
  - the immediate-generation function imm_gen(inst, XLEN).
- Sub-module regfile_bypass (NREG, XLEN): one write port, three bypassed read ports (rs1, rs2, dbg).

Test Plan:
- Reset then idle: rst high 2 cycles -> out_valid=0, out_opcode=0x13, in_ready=1, dbg_rdata=0 for every dbg_raddr.
- Write/read with bypass: wb_en=1, wb_rd=5, wb_data=0xDEAD in the same cycle in_inst=add x1,x5,x5 loads -> next cycle out_data1=out_data2=0xDEAD; one write to x0 -> reads 0.
- Immediates:
  - in_inst=0xFFF00093 (addi x1,x0,-1) -> out_imm=all ones.
  - in_inst=0xFE000EE3 (beq x0,x0,-4) -> out_imm=-4.
  - in_inst=0x800000B7 (lui) -> out_imm=0xFFFFFFFF80000000 at XLEN=64.
- Stall refresh: load add x3,x7,x8 with out_ready=0, then wb_en=1, wb_rd=8, wb_data=0x55 -> out_data2=0x55, out_data1 unchanged, in_ready=0 throughout stall, and a new in_valid is not taken.
- Flush during stall: out_valid=1, out_ready=0, flush=1 with in_valid=1 -> next cycle out_valid=0, opcode=0x13; in_inst is not captured; a coincident wb to x9 is visible via dbg_raddr=9.
- NREG=16 build: wb_rd=20 write -> ignored; read x20 -> 0.
